load_scoreboard_ctrl: RTL
=========================

Name: load_scoreboard_ctrl

Overview:
Issue controller for the ID stage once loads become variable-latency, returning out of order through a split-transaction LSU.
- Keeps a registered per-register scoreboard (busy, load-pending) that is set when a load issues and cleared when its response returns.
- Counts outstanding loads and stalls ID on RAW, WAW, structural-full and fence-drain conditions.
- Sits between the decode outputs and the ID/EX pipeline register; single-cycle ALU hazards stay with the existing EX-vs-ID compare.

Parameters:
MAX_OUTSTANDING, 4, maximum loads in flight (1..15)
RESP_BYPASS, 1, when 1 a register whose load response arrives this cycle is treated as not busy for the hazard check (WB forwards that data)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
issue_valid_id  in  1  ID holds a valid instruction
rs1_id  in  5  source 1
rs2_id  in  5  source 2
use_rs1_id  in  1  rs1 is actually read
use_rs2_id  in  1  rs2 is actually read
rd_id  in  5  destination
rd_write_en_id  in  1  instruction writes rd
is_load_id  in  1  instruction is a load
is_fence_id  in  1  instruction is a FENCE
lsu_req_ready  in  1  LSU can accept a load request this cycle
lsu_resp_valid  in  1  load response retiring this cycle
lsu_resp_rd  in  5  destination of the retiring load
issue_fire  out  1  ID instruction advances this cycle
stall_id  out  1  issue_valid_id & ~issue_fire
stall_cause  out  2  0 none, 1 RAW, 2 WAW, 3 structural/drain
outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  loads in flight
busy_vec  out  32  registered busy bits
draining  out  1  FSM in DRAIN
err_spurious  out  1  sticky: a response arrived that matched no pending load

Behaviour:
- Reset (rst=0, async): busy and load-pending bits = 0, outstanding_cnt = 0, FSM = RUN, err_spurious = 0. All combinational outputs then evaluate to 0.
- Effective busy: eff_busy[r] = busy[r] & ~(RESP_BYPASS & lsu_resp_valid & lsu_resp_rd==r). Register x0 is never busy.
- RAW: (use_rs1_id & eff_busy[rs1_id]) | (use_rs2_id & eff_busy[rs2_id]).
- WAW: rd_write_en_id & rd_id!=0 & eff_busy[rd_id]. This applies to any writer, load or ALU, so a late load cannot overwrite a newer result.
- Structural:
  - is_load_id & (~lsu_req_ready | cnt_eff==MAX_OUTSTANDING), where cnt_eff = outstanding_cnt - (lsu_resp_valid & valid response).
  - or is_fence_id & cnt_eff!=0.
- Stall priority for stall_cause: RAW > WAW > structural.
- issue_fire = issue_valid_id & no hazard. Purely combinational, so it has zero latency.
- Scoreboard update on posedge:
  - Load fire with rd!=0: set busy[rd] and load-pending[rd].
  - Valid response: clear busy[lsu_resp_rd].
  - Set and clear on the same register in the same cycle (only possible with RESP_BYPASS=1): set wins.
- Counter:
  - +1 on load fire (including rd==0 loads, which hold no busy bit).
  - -1 on a valid response.
  - Both in one cycle: unchanged. It never exceeds MAX_OUTSTANDING.
- Spurious response (lsu_resp_valid with outstanding_cnt==0):
  - Sets err_spurious.
  - Counter stays 0; the scoreboard clear still applies.
  - err_spurious clears only on reset.
- FSM:
  - RUN -> DRAIN when issue_valid_id & is_fence_id & cnt_eff!=0.
  - DRAIN: draining=1, stall_cause=3 for the fence.
  - DRAIN -> RUN in the cycle cnt_eff==0; the fence fires in that same cycle.
  - DRAIN -> RUN if issue_valid_id drops (fence flushed); no state is lost.
- Flushes never clear busy bits: issued loads still return and retire normally.

Test Plan:
- Reset, then a load x5 with lsu_req_ready=1 -> issue_fire=1; next cycle busy_vec=0x20, outstanding_cnt=1.
- While x5 is busy, ADD x6,x5,x1 -> stall_id=1, stall_cause=1. With lsu_resp_valid, rd=5 and RESP_BYPASS=1 -> issue_fire=1 in that cycle, and busy_vec=0 the following cycle.
- Load x7 pending, then ADDI x7 -> stall_cause=2 until the x7 response, then fires.
- MAX_OUTSTANDING=4: issue loads x1..x4, then a fifth load x8 -> stall_cause=3. A response plus the load in the same cycle -> fires, outstanding_cnt stays 4.
- FENCE with 2 loads pending -> draining=1 for the drain cycles; the fence fires in the cycle the second response arrives, and the FSM returns to RUN.
- lsu_resp_valid with outstanding_cnt=0 -> err_spurious=1 and stays set. Assert rst=0 mid-stream with 3 loads pending -> all outputs clear at once, without waiting for a clock.

Source files
------------

// File: rtl/load_scoreboard_ctrl.sv
// ID-stage issue controller for out-of-order returning loads: a per-register
// scoreboard, an outstanding-load counter and a RUN/DRAIN fence FSM (RUN | normal issue, DRAIN | fence waits for loads).
module load_scoreboard_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_BYPASS     = 1,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_issue_valid_id,
  input  logic [4:0]    i_rs1_id,
  input  logic [4:0]    i_rs2_id,
  input  logic          i_use_rs1_id,
  input  logic          i_use_rs2_id,
  input  logic [4:0]    i_rd_id,
  input  logic          i_rd_write_en_id,
  input  logic          i_is_load_id,
  input  logic          i_is_fence_id,
  input  logic          i_lsu_req_ready,
  input  logic          i_lsu_resp_valid,
  input  logic [4:0]    i_lsu_resp_rd,
  output logic          o_issue_fire,
  output logic          o_stall_id,
  output logic [1:0]    o_stall_cause,
  output logic [CW-1:0] o_outstanding_cnt,
  output logic [31:0]   o_busy_vec,
  output logic          o_draining,
  output logic          o_err_spurious
);

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

  state_t        r_state;
  logic [31:0]   r_busy;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_active;
  logic          w_resp_ok;
  logic [CW-1:0] w_cnt_eff;
  logic [31:0]   w_resp_mask;
  logic [31:0]   w_eff_busy;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_fire;
  logic          w_load_fire;
  logic          w_fence_wait;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;

  // Combinational outputs are forced low while reset is held, independent of ID inputs.
  assign w_active    = i_rst_n & i_issue_valid_id;
  assign w_resp_ok   = i_lsu_resp_valid & (r_cnt != '0);
  assign w_cnt_eff   = r_cnt - CW'(w_resp_ok);
  assign w_resp_mask = 32'h1 << i_lsu_resp_rd;
  assign w_eff_busy  = r_busy & ~32'h1 &
                       ~(((RESP_BYPASS != 0) && i_lsu_resp_valid) ? w_resp_mask : 32'h0);

  assign w_raw    = (i_use_rs1_id & w_eff_busy[i_rs1_id]) |
                    (i_use_rs2_id & w_eff_busy[i_rs2_id]);
  assign w_waw    = i_rd_write_en_id & (i_rd_id != 5'd0) & w_eff_busy[i_rd_id];
  assign w_struct = (i_is_load_id & (~i_lsu_req_ready | (w_cnt_eff == C_MAX))) |
                    (i_is_fence_id & (w_cnt_eff != '0));

  assign w_fire       = w_active & ~(w_raw | w_waw | w_struct);
  assign w_load_fire  = w_fire & i_is_load_id;
  assign w_fence_wait = w_active & i_is_fence_id & (w_cnt_eff != '0);

  // Loads to x0 count as in flight but never mark the scoreboard.
  assign w_set = (w_load_fire && (i_rd_id != 5'd0)) ? (32'h1 << i_rd_id) : 32'h0;
  assign w_clr = i_lsu_resp_valid ? w_resp_mask : 32'h0;

  always_comb begin
    o_stall_cause = 2'd0;
    if (w_active) begin
      if (w_raw)         o_stall_cause = 2'd1;
      else if (w_waw)    o_stall_cause = 2'd2;
      else if (w_struct) o_stall_cause = 2'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_busy  <= 32'h0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;

      if (w_load_fire && !w_resp_ok)      r_cnt <= r_cnt + CW'(1);
      else if (!w_load_fire && w_resp_ok) r_cnt <= r_cnt - CW'(1);

      if (i_lsu_resp_valid && (r_cnt == '0)) r_err <= 1'b1;

      case (r_state)
        S_RUN:   if (w_fence_wait)  r_state <= S_DRAIN;
        S_DRAIN: if (!w_fence_wait) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_issue_fire      = w_fire;
  assign o_stall_id        = w_active & ~w_fire;
  assign o_outstanding_cnt = r_cnt;
  assign o_busy_vec        = r_busy;
  assign o_draining        = (r_state == S_DRAIN);
  assign o_err_spurious    = r_err;

endmodule
